// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared WS2812 receiver state type and default timing constants
package ws_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } ws_state_e;

    localparam int unsigned WS_BIT_THRESH = 29;
    localparam int unsigned WS_MIN_HIGH   = 8;
    localparam int unsigned WS_MAX_HIGH   = 64;
    localparam int unsigned WS_GAP_CYCLES = 2400;
    localparam int unsigned WS_WORD_BITS  = 24;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - saturating cycle counter with sync clear and >= compare
module pulse_timer #(
    parameter int unsigned W   = 12,
    parameter int unsigned SAT = 4095
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] thresh_i,
    output logic [W-1:0] count_o,
    output logic         ge_o
);

    localparam logic [W-1:0] SAT_V = W'(SAT);

    logic [W-1:0] count_q, count_d;

    // A clear restarts at 1 when enabled so the clearing cycle itself is counted
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = en_i ? W'(1) : '0;
        end else if (en_i && (count_q < SAT_V)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign ge_o    = (count_q >= thresh_i);

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 serial receiver to 24-bit GRB words; define WS_RX_FORWARD_EN for dout chaining
module ws2812_rx
    import ws_pkg::*;
#(
    parameter int unsigned BIT_THRESH = WS_BIT_THRESH,
    parameter int unsigned MIN_HIGH   = WS_MIN_HIGH,
    parameter int unsigned MAX_HIGH   = WS_MAX_HIGH,
    parameter int unsigned GAP_CYCLES = WS_GAP_CYCLES,
    parameter int unsigned IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             pixel_ready,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_idx,
    output logic             frame_done,
    output logic             err_bit,
    output logic             err_overrun,
    output logic             dout
);

    localparam int unsigned   CW       = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] MIN_V    = CW'(MIN_HIGH);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_HIGH);
    localparam logic [CW-1:0] BIT_V    = CW'(BIT_THRESH);
    localparam logic [CW-1:0] GAP_V    = CW'(GAP_CYCLES);
    localparam logic [4:0]    LAST_BIT = 5'(WS_WORD_BITS - 1);

    logic din_s1_q, din_s2_q, din_prev_q;
    logic rise, fall;

    ws_state_e        state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [22:0]      shreg_q, shreg_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
    logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             err_bit_q, err_bit_d;
    logic             err_overrun_q, err_overrun_d;
    logic             got_bit_q, got_bit_d;
    logic             bit_valid, bit_val;

    // One run-length counter serves as hcnt while HIGH and lcnt while LOW/ARM,
    // since the line is only ever in one level; it restarts on every edge.
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_thresh;
    logic          run_ge;

    assign rise       = din_s2_q & ~din_prev_q;
    assign fall       = ~din_s2_q & din_prev_q;
    assign run_thresh = (state_q == ST_HIGH) ? BIT_V : GAP_V;

    // Two-flop synchronizer plus one stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_s1_q   <= 1'b0;
            din_s2_q   <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            din_s1_q   <= din;
            din_s2_q   <= din_s1_q;
            din_prev_q <= din_s2_q;
        end
    end

    pulse_timer #(
        .W   (CW),
        .SAT (GAP_CYCLES)
    ) u_run_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (rise | fall),
        .en_i     (1'b1),
        .thresh_i (run_thresh),
        .count_o  (run_cnt),
        .ge_o     (run_ge)
    );

    // Next-state: pulse decode, word assembly, latch handling and output handshake
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = pixel_valid_q & ~pixel_ready;
        pixel_idx_d   = pixel_idx_q;
        word_cnt_d    = word_cnt_q;
        frame_done_d  = 1'b0;
        err_bit_d     = err_bit_q;
        err_overrun_d = err_overrun_q;
        got_bit_d     = got_bit_q;
        bit_valid     = 1'b0;
        bit_val       = 1'b0;

        case (state_q)
            ST_ARM: begin
                if (!din_s2_q && run_ge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (run_cnt > MAX_V) begin
                    // Stuck-high line: drop the frame in progress and rearm
                    state_d    = ST_ARM;
                    err_bit_d  = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    got_bit_d  = 1'b0;
                end else if (fall) begin
                    state_d = ST_LOW;
                    if (run_cnt < MIN_V) begin
                        err_bit_d = 1'b1;
                    end else begin
                        bit_valid = 1'b1;
                        bit_val   = run_ge;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (!din_s2_q && run_ge) begin
                    state_d      = ST_IDLE;
                    frame_done_d = got_bit_q;
                    got_bit_d    = 1'b0;
                    if (bit_cnt_q != 5'd0) begin
                        err_bit_d = 1'b1;
                    end
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            default: state_d = ST_ARM;
        endcase

        if (bit_valid) begin
            got_bit_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
                pixel_data_d  = {shreg_q, bit_val};
                pixel_valid_d = 1'b1;
                pixel_idx_d   = word_cnt_q;
                word_cnt_d    = word_cnt_q + IDX_W'(1);
                bit_cnt_d     = '0;
                if (pixel_valid_q && !pixel_ready) begin
                    err_overrun_d = 1'b1;
                end
            end else begin
                shreg_d   = {shreg_q[21:0], bit_val};
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ARM;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_idx_q   <= '0;
            word_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            err_bit_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            got_bit_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_idx_q   <= pixel_idx_d;
            word_cnt_q    <= word_cnt_d;
            frame_done_q  <= frame_done_d;
            err_bit_q     <= err_bit_d;
            err_overrun_q <= err_overrun_d;
            got_bit_q     <= got_bit_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_idx   = pixel_idx_q;
    assign frame_done  = frame_done_q;
    assign err_bit     = err_bit_q;
    assign err_overrun = err_overrun_q;

`ifdef WS_RX_FORWARD_EN
    logic fwd_en_q, dout_q;

    // Pass the line downstream once this receiver has taken its own word, until the latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_en_q <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            if (state_q == ST_LOW && state_d == ST_IDLE) begin
                fwd_en_q <= 1'b0;
            end else if (bit_valid && bit_cnt_q == LAST_BIT) begin
                fwd_en_q <= 1'b1;
            end
            dout_q <= fwd_en_q & din_s2_q;
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

endmodule
